// File: rtl/ifetch_unit_pkg.sv
// rtl/ifetch_unit_pkg.sv - shared widths, constants and fetch-queue entry type for the fetch unit
package ifetch_unit_pkg;

    localparam int XLEN          = 32;
    localparam int INSTR_WIDTH   = 32;
    localparam int FETCH_Q_DEPTH = 2;

    localparam logic [XLEN-1:0]        RESET_PC_DEF = 32'h0000_0000;
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR    = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_fetch_queue.sv
// rtl/ifetch_unit_fetch_queue.sv - synchronous FIFO with flush and occupancy count
module ifetch_unit_fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: rd_data is only meaningful while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - PC owner issuing one imem read per cycle under queue credit, with redirect flush
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
    parameter int              FIFO_DEPTH = FETCH_Q_DEPTH,
    parameter int              IMEM_AW    = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [IMEM_AW-1:0]     imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [XLEN-1:0]        out_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] issue_pc;
    logic [SW-1:0]   credit_use;
    logic            push, pop, handshake;
    logic [CW-1:0]   q_count;
    fetch_entry_t    wr_entry, rd_entry;

    always_comb begin
        issue_pc   = redirect ? align_pc(redirect_pc) : pc_q;
        handshake  = out_valid & out_ready;
        // A redirect voids the pop: the flush already discards the head.
        pop        = handshake & !redirect;
        push       = inflight_q & !redirect;
        credit_use = SW'(q_count) + SW'(inflight_q) - SW'(handshake);
        imem_req   = !rst && (redirect || (credit_use < SW'(FIFO_DEPTH)));
        imem_addr  = issue_pc[IMEM_AW+1:2];
        pc_d       = imem_req ? issue_pc + XLEN'(4) : pc_q;
        req_pc_d   = imem_req ? issue_pc : req_pc_q;
        inflight_d = imem_req;
        wr_entry   = '{pc: req_pc_q, instr: imem_rdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    ifetch_unit_fetch_queue #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_queue (
        .clk     (clk),
        .rst     (rst),
        .flush   (redirect),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .count   (q_count)
    );

    always_comb begin
        out_valid = (q_count != '0);
        out_instr = out_valid ? rd_entry.instr : NOP_INSTR;
        out_pc    = out_valid ? rd_entry.pc : '0;
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - randomized self-checking bench for ifetch_unit against a stream-level model
module tb_ifetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [1024];

    // Stream-level model: next PC to be delivered, next PC to be requested,
    // words available in the queue, and whether a valid response arrives next cycle.
    logic [31:0] exp_out_pc;
    logic [31:0] next_issue_pc;
    int          avail;
    bit          pend;

    ifetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2),
        .IMEM_AW    (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst)           imem_rdata <= 32'hDEAD_BEEF;
        else if (imem_req) imem_rdata <= mem[imem_addr];
        else               imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit       pop;
        bit       exp_req;
        if (rst) begin
            check("rst_valid", 64'(out_valid), 64'd0);
            check("rst_req",   64'(imem_req),  64'd0);
            check("rst_instr", 64'(out_instr), 64'h13);
            check("rst_pc",    64'(out_pc),    64'd0);
            exp_out_pc    = 32'h0;
            next_issue_pc = 32'h0;
            avail         = 0;
            pend          = 1'b0;
        end else begin
            check("out_valid", 64'(out_valid), 64'(avail > 0));
            if (redirect) begin
                check("redir_req",  64'(imem_req),  64'd1);
                check("redir_addr", 64'(imem_addr), 64'(redirect_pc[11:2]));
                exp_out_pc    = {redirect_pc[31:2], 2'b00};
                next_issue_pc = {redirect_pc[31:2], 2'b00} + 32'd4;
                avail         = 0;
                pend          = 1'b1;
            end else begin
                if (avail > 0) begin
                    check("out_pc",    64'(out_pc),    64'(exp_out_pc));
                    check("out_instr", 64'(out_instr), 64'(mem[exp_out_pc[11:2]]));
                end else begin
                    check("idle_instr", 64'(out_instr), 64'h13);
                    check("idle_pc",    64'(out_pc),    64'd0);
                end
                pop     = (avail > 0) && out_ready;
                exp_req = (avail + int'(pend) - int'(pop)) < 2;
                check("imem_req", 64'(imem_req), 64'(exp_req));
                if (exp_req) begin
                    check("imem_addr", 64'(imem_addr), 64'(next_issue_pc[11:2]));
                    next_issue_pc = next_issue_pc + 32'd4;
                end
                if (pop) exp_out_pc = exp_out_pc + 32'd4;
                avail = avail - int'(pop) + int'(pend);
                pend  = exp_req;
            end
        end
    end

    task automatic expect_next(input string name, input logic [31:0] exp);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        if (!out_valid) check({name, "_timeout"}, 64'd0, 64'd1);
        else            check(name, 64'(out_pc), 64'(exp));
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        @(posedge clk); #1;
        redirect    = 1'b1;
        redirect_pc = pc;
        @(posedge clk); #1;
        redirect    = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset release: addresses 0,1,2 and PCs 0x0, 0x4 from t+2
        @(negedge clk);
        check("t0_req",   64'(imem_req),  64'd1);
        check("t0_addr",  64'(imem_addr), 64'd0);
        check("t0_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t1_addr",  64'(imem_addr), 64'd1);
        @(negedge clk);
        check("t2_valid", 64'(out_valid), 64'd1);
        check("t2_pc",    64'(out_pc),    64'h0);
        check("t2_addr",  64'(imem_addr), 64'd2);
        @(negedge clk);
        check("t3_pc",    64'(out_pc),    64'h4);
        repeat (4) @(negedge clk);

        // Backpressure for 6 cycles, then release
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (6) @(negedge clk);
        check("bp_req_low", 64'(imem_req),  64'd0);
        check("bp_valid",   64'(out_valid), 64'd1);
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Redirect with the queue full
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (4) @(negedge clk);
        do_redirect(32'h0000_0100);
        out_ready = 1'b1;
        expect_next("redir_full_0", 32'h0000_0100);
        expect_next("redir_full_1", 32'h0000_0104);
        repeat (4) @(negedge clk);

        // Redirect while streaming: head handshake and returning response both voided
        @(posedge clk); #1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        check("stream_redir_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1 redirect = 1'b0;
        expect_next("stream_redir_0", 32'h0000_0200);
        expect_next("stream_redir_1", 32'h0000_0204);

        // PC and imem address wrap
        @(posedge clk); #1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        check("wrap_addr0", 64'(imem_addr), 64'h3FE);
        @(posedge clk); #1 redirect = 1'b0;
        @(negedge clk);
        check("wrap_addr1", 64'(imem_addr), 64'h3FF);
        expect_next("wrap_pc0", 32'hFFFF_FFF8);
        check("wrap_addr2", 64'(imem_addr), 64'h000);
        expect_next("wrap_pc1", 32'hFFFF_FFFC);
        expect_next("wrap_pc2", 32'h0000_0000);

        // Random backpressure and redirects, including back-to-back
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            redirect  = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: redirect_pc = $urandom;
            endcase
        end
        @(posedge clk); #1;
        redirect  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);

        // Unaligned redirect target, then reset mid-stream
        do_redirect(32'h0000_0102);
        expect_next("unaligned_pc", 32'h0000_0100);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_req",   64'(imem_req),  64'd0);
        check("midrst_instr", 64'(out_instr), 64'h13);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rerst_addr", 64'(imem_addr), 64'd0);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
